// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters.
// A grant lasts for a whole message; a stalled owner is released after LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned ACK_TIMEOUT  = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 arb_busy,
    output logic                 lock_err
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(NUM_REQ - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, HOLD} state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    owner, owner_d, ptr, ptr_d, rr_sel;
    logic                rr_found, last_q, last_d;
    logic [ACK_W-1:0]    ack_cnt, ack_d;
    logic [LOCK_W-1:0]   idle_cnt, idle_d;
    logic [NUM_REQ-1:0]  grant_d, ready_d;
    logic [7:0]          tx_data_d;
    logic                start_d, lock_d;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!rr_found && req_valid[IDX_W'((32'(ptr) + i) % NUM_REQ)]) begin
                rr_found = 1'b1;
                rr_sel   = IDX_W'((32'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            last_q    <= 1'b0;
            ack_cnt   <= '0;
            idle_cnt  <= '0;
            grant     <= '0;
            req_ready <= '0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            lock_err  <= 1'b0;
            arb_busy  <= 1'b0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            ptr       <= ptr_d;
            last_q    <= last_d;
            ack_cnt   <= ack_d;
            idle_cnt  <= idle_d;
            grant     <= grant_d;
            req_ready <= ready_d;
            tx_data   <= tx_data_d;
            tx_start  <= start_d;
            lock_err  <= lock_d;
            arb_busy  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d   = state;
        owner_d   = owner;
        ptr_d     = ptr;
        last_d    = last_q;
        ack_d     = ack_cnt;
        idle_d    = idle_cnt;
        grant_d   = grant;
        ready_d   = '0;
        tx_data_d = tx_data;
        start_d   = 1'b0;
        lock_d    = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    owner_d = rr_sel;
                    grant_d = NUM_REQ'(1) << rr_sel;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!req_valid[owner]) begin
                    idle_d  = '0;
                    state_d = HOLD;
                end else if (!tx_busy) begin
                    tx_data_d = req_data[{owner, 3'b000} +: 8];
                    last_d    = req_last[owner];
                    ready_d   = grant;
                    start_d   = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                ack_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // No ack within the window: assume the byte was taken, never resend.
                if (tx_busy || ack_cnt == ACK_LAST) begin
                    state_d = WAIT_DONE;
                end else begin
                    ack_d = ack_cnt + ACK_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = (owner == IDX_MAX) ? '0 : owner + IDX_W'(1);
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            HOLD: begin
                if (req_valid[owner]) begin
                    state_d = LOAD;
                end else if (idle_cnt == LOCK_LAST) begin
                    lock_d  = 1'b1;
                    grant_d = '0;
                    ptr_d   = (owner == IDX_MAX) ? '0 : owner + IDX_W'(1);
                    state_d = IDLE;
                end else begin
                    idle_d = idle_cnt + LOCK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers, a UART model and a round-robin
// message-order reference model feeding an expected-byte queue checked on every tx_start.
module tb_uart_tx_arbiter;
    localparam int NR = 3;
    localparam int ACK_TO = 4;
    localparam int LOCK_TO = 16;

    typedef struct packed {logic [7:0] data; logic last; logic [7:0] gap;} item_t;
    typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [NR-1:0] req_valid, req_last, req_ready, grant;
    logic [8*NR-1:0] req_data;
    logic [7:0] tx_data;
    logic tx_start, tx_busy, arb_busy, lock_err;
    logic uart_busy, force_busy;
    assign tx_busy = uart_busy | force_busy;

    item_t rq[NR][$];
    exp_t exp_q[$];
    int total = 0, bad = 0, starts = 0, readies = 0, locks = 0, cyc = 0;
    int mp = 0, uart_mode = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(ACK_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .arb_busy(arb_busy), .lock_err(lock_err));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Requesters: present head byte, hold it until req_ready, honour per-byte gaps.
    initial begin
        int wt[NR];
        req_valid = '0; req_last = '0; req_data = '0;
        for (int i = 0; i < NR; i++) wt[i] = 0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    void'(rq[i].pop_front());
                    req_valid[i] = 1'b0;
                    wt[i] = 0;
                end
                if (rq[i].size() == 0) begin
                    req_valid[i] = 1'b0;
                    wt[i] = 0;
                end else if (!req_valid[i]) begin
                    if (wt[i] >= int'(rq[i][0].gap)) begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = rq[i][0].data;
                        req_last[i] = rq[i][0].last;
                    end else begin
                        wt[i]++;
                    end
                end
            end
        end
    end

    // UART model: busy rises 0..2 cycles after tx_start and lasts a random frame time.
    initial begin
        int dly, blen, flen;
        logic [7:0] fdata;
        uart_busy = 1'b0; dly = -1; blen = 0; flen = 0; fdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                uart_busy = 1'b0; dly = -1;
            end else begin
                if (tx_start && uart_mode == 0) begin
                    dly = $urandom_range(0, 2);
                    flen = $urandom_range(2, 6);
                    fdata = tx_data;
                end
                if (dly == 0) begin
                    uart_busy = 1'b1; blen = flen; dly = -1;
                end else if (dly > 0) begin
                    dly--;
                end
                if (uart_busy) begin
                    chk("tx_data_stable", int'(tx_data), int'(fdata));
                    if (blen == 0) uart_busy = 1'b0;
                    else blen--;
                end
            end
        end
    end

    // Monitor: every tx_start must carry the next expected byte from the expected owner.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (lock_err) locks++;
            if (tx_start) begin
                starts++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_tx_start: data %02h grant %b, nothing expected", tx_data, grant);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", int'(tx_data), int'(e.data));
                    chk("tx_owner", int'(grant), int'(NR'(1) << e.id));
                end
            end
            if (req_ready != '0) begin
                readies++;
                chk("ready_is_owner", int'(req_ready & ~grant) + ($countones(req_ready) == 1 ? 0 : 100), 0);
            end
        end
    end

    // Reference model: whole messages served round-robin from the model pointer.
    task automatic plan();
        item_t cp[NR][$];
        item_t it;
        exp_t e;
        int sel;
        bit found;
        for (int i = 0; i < NR; i++) cp[i] = rq[i];
        found = 1'b1;
        while (found) begin
            found = 1'b0; sel = 0;
            for (int k = 0; k < NR; k++)
                if (!found && cp[(mp + k) % NR].size() > 0) begin
                    found = 1'b1; sel = (mp + k) % NR;
                end
            if (found) begin
                do begin
                    it = cp[sel].pop_front();
                    e.id = 2'(sel); e.data = it.data;
                    exp_q.push_back(e);
                end while (!it.last && cp[sel].size() > 0);
                mp = (sel + 1) % NR;
            end
        end
    endtask

    task automatic add_msg(input int r, input int len, input logic [7:0] d0, input bit rnd);
        item_t it;
        for (int k = 0; k < len; k++) begin
            it.data = rnd ? 8'($urandom) : d0 + 8'(k);
            it.last = (k == len - 1);
            it.gap  = (rnd && k > 0) ? 8'($urandom_range(0, 4)) : 8'd0;
            rq[r].push_back(it);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id = 2'(id); e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_tx_start"}, int'(tx_start), 0);
        chk({tag, "_lock_err"}, int'(lock_err), 0);
        chk({tag, "_arb_busy"}, int'(arb_busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        mp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        bit busy = 1'b1;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
            busy = (exp_q.size() != 0) || arb_busy || tx_busy;
            for (int i = 0; i < NR; i++) if (rq[i].size() != 0) busy = 1'b1;
        end
        chk({nm, "_done_in_budget"}, int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s0, r0, l0, c0, c1, nb, n;
        force_busy = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester, three bytes.
        s0 = starts; r0 = readies;
        add_msg(0, 3, 8'h41, 1'b0); plan();
        wait_idle("t1", 500);
        chk("t1_starts", starts - s0, 3);
        chk("t1_readies", readies - r0, 3);
        chk("t1_grant_free", int'(grant), 0);

        // All three requesters, then a second message from requester 0.
        do_reset();
        s0 = starts;
        add_msg(0, 2, 8'h10, 1'b0); add_msg(0, 2, 8'h18, 1'b0);
        add_msg(1, 2, 8'h20, 1'b0); add_msg(2, 2, 8'h30, 1'b0);
        plan();
        wait_idle("t2", 1000);
        chk("t2_starts", starts - s0, 8);

        // Owner 1 stalls mid-message; requester 2 waits for the lock timeout.
        s0 = starts; r0 = readies; l0 = locks;
        rq[1].push_back('{data: 8'h55, last: 1'b0, gap: 8'd0});
        add_msg(2, 2, 8'h60, 1'b0);
        push_exp(1, 8'h55); push_exp(2, 8'h60); push_exp(2, 8'h61);
        mp = 0;
        n = 0;
        while (readies == r0 && n < 200) begin @(negedge clk); n++; end
        c0 = cyc;
        n = 0;
        while (locks == l0 && n < 200) begin
            @(negedge clk); n++;
            if (arb_busy && locks == l0) chk("t3_hold_grant", int'(grant), 2);
        end
        c1 = cyc;
        chk("t3_lock_seen", locks - l0, 1);
        chk("t3_lock_not_early", int'((c1 - c0) >= LOCK_TO), 1);
        chk("t3_lock_not_late", int'((c1 - c0) < LOCK_TO + 40), 1);
        wait_idle("t3", 500);
        chk("t3_starts", starts - s0, 3);
        chk("t3_lock_once", locks - l0, 1);

        // UART never acknowledges: each byte still sent exactly once.
        uart_mode = 1;
        s0 = starts;
        add_msg(2, 2, 8'h70, 1'b0); plan();
        wait_idle("t4", 500);
        chk("t4_starts", starts - s0, 2);
        uart_mode = 0;

        // Transmitter already busy when the grant arrives.
        force_busy = 1'b1;
        s0 = starts;
        add_msg(1, 1, 8'h80, 1'b0); plan();
        repeat (12) @(negedge clk);
        chk("t5_no_start_while_busy", starts - s0, 0);
        chk("t5_grant", int'(grant), 2);
        force_busy = 1'b0;
        wait_idle("t5", 500);
        chk("t5_starts", starts - s0, 1);

        // Reset while waiting for the frame to finish.
        s0 = starts;
        add_msg(0, 3, 8'h90, 1'b0); plan();
        n = 0;
        while (starts == s0 && n < 200) begin @(negedge clk); n++; end
        chk("t6_first_start", starts - s0, 1);
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_owned", int'(grant), 1);
        rst_n = 1'b0;
        #1 check_reset_outputs("t6_rst");
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        mp = 0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s0 = starts;
        add_msg(2, 1, 8'hA0, 1'b0); add_msg(0, 1, 8'hB0, 1'b0);
        plan();
        wait_idle("t6", 500);
        chk("t6_starts", starts - s0, 2);

        // Randomized message mixes with intra-message gaps.
        for (int round = 0; round < 8; round++) begin
            s0 = starts; nb = 0;
            for (int r = 0; r < NR; r++) begin
                n = $urandom_range(0, 2);
                for (int m = 0; m < n; m++) begin
                    c0 = $urandom_range(1, 4);
                    add_msg(r, c0, 8'h00, 1'b1);
                    nb += c0;
                end
            end
            plan();
            wait_idle("rnd", 3000);
            chk("rnd_starts", starts - s0, nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
